mcc_cmd_rx_parse: RTL

Upstream command parser for the MCC UDP link. It receives the UDP payload byte stream from the UDP RX stage and parses the 16-byte MCC message header (length, pkg_cnt, reserved, Message_ID, all big-endian uint32). It validates each frame and drives single-cycle start pulses (req ack / req nack / status request plus option code) into the packet assembler. Pulses are held off while the assembler reports it is running.

---
 rtl/mcc_proto_pkg.sv | 38 +++
 rtl/mcc_rx_byte_to_word.sv | 33 +++
 rtl/mcc_cmd_rx_parse.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mcc_proto_pkg.sv
// MCC protocol constants, option codes and shared parser types.
// Message IDs and field sizes follow the MCC UDP wire format (big-endian uint32 fields).
package mcc_proto_pkg;

  localparam int          MCC_HDR_BYTES     = 16;
  localparam logic [31:0] MCC_ID_REQ        = 32'd10;
  localparam logic [31:0] MCC_ID_STATUS_REQ = 32'd100;
  localparam logic [31:0] MCC_ID_ACK        = 32'd11;
  localparam logic [31:0] MCC_ID_NACK       = 32'd12;
  localparam logic [31:0] MCC_ID_STATUS_RSP = 32'd200;

  typedef enum logic [2:0] {
    OPT_NONE             = 3'd0,
    OPT_SYS_STATUS       = 3'd1,
    OPT_LINK_STATUS      = 3'd2,
    OPT_TEMP_STATUS      = 3'd3,
    OPT_POWER_STATUS     = 3'd4,
    OPT_FAULT_STATUS     = 3'd5,
    OPT_VERSION_STATUS   = 3'd6,
    OPT_AUTO_TEST_STATUS = 3'd7
  } opt_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECK,
    ST_ISSUE,
    ST_DROP
  } rx_state_t;

  typedef enum logic [1:0] {
    KIND_ACK,
    KIND_NACK,
    KIND_STATUS
  } rx_kind_t;

endpackage

// File: rtl/mcc_rx_byte_to_word.sv
// Big-endian 4-byte shifter: word_dat is the word including the current byte, word_vld marks its 4th byte.
// Combinational word output (zero latency); no backpressure, one byte per shift_en.
module mcc_rx_byte_to_word (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word_dat,
  output logic        word_vld
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  assign word_dat = {shreg, byte_dat};
  assign word_vld = shift_en && !clr && (cnt == 2'd3);

  // clr together with shift_en makes the current byte the first of a new word
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= shift_en ? {16'd0, byte_dat} : 24'd0;
      cnt   <= shift_en ? 2'd1 : 2'd0;
    end else if (shift_en) begin
      shreg <= word_dat[23:0];
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/mcc_cmd_rx_parse.sv
// MCC command parser: header/payload parse, frame classification, one start pulse per frame.
// Pulse 2 cycles after the last byte; held in ISSUE while the assembler is busy, bytes then are dropped.
module mcc_cmd_rx_parse
  import mcc_proto_pkg::*;
#(
  parameter logic [31:0] MSG_ID_REQ        = MCC_ID_REQ,
  parameter logic [31:0] MSG_ID_STATUS_REQ = MCC_ID_STATUS_REQ,
  parameter int          MAX_PAYLOAD_BYTES = 1472,
  parameter int          CNT_W             = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_data_valid,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_data_last,
  input  logic             i_rx_frame_err,
  input  logic             i_assemble_pkg_is_running,
  output logic             o_req_ack_start_en,
  output logic             o_req_nack_start_en,
  output logic             o_status_request_start_en,
  output logic [2:0]       o_status_request_data,
  output logic [31:0]      o_rx_pkg_cnt,
  output logic [CNT_W-1:0] o_rx_good_cnt,
  output logic [CNT_W-1:0] o_rx_err_cnt,
  output logic             o_parser_busy
);

  localparam int               PAY_W   = $clog2(MAX_PAYLOAD_BYTES + 2);
  localparam logic [PAY_W-1:0] PAY_SAT = PAY_W'(MAX_PAYLOAD_BYTES + 1);

  rx_state_t        state, state_nxt;
  rx_kind_t         kind_q, kind_nxt;
  logic [3:0]       hdr_idx;
  logic [PAY_W-1:0] pay_cnt;
  logic [31:0]      len_q, pkg_cnt_q, msg_id_q;
  logic [2:0]       opt_q;
  logic             runt_q, err_q, in_frame, in_frame_nxt;
  logic             parsing, oversize, pulse_en;
  logic [31:0]      word_dat;
  logic             word_vld;

  assign parsing      = state inside {ST_IDLE, ST_HEADER, ST_PAYLOAD};
  assign oversize     = (pay_cnt == PAY_SAT);
  assign in_frame_nxt = i_rx_data_valid ? !i_rx_data_last : in_frame;
  assign pulse_en     = (state == ST_ISSUE) && !i_assemble_pkg_is_running;

  assign o_req_ack_start_en        = pulse_en && (kind_q == KIND_ACK);
  assign o_req_nack_start_en       = pulse_en && (kind_q == KIND_NACK);
  assign o_status_request_start_en = pulse_en && (kind_q == KIND_STATUS);
  assign o_parser_busy             = (state != ST_IDLE);

  mcc_rx_byte_to_word u_b2w (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .clr       (state == ST_IDLE),
    .shift_en  (i_rx_data_valid && parsing),
    .byte_dat  (i_rx_data),
    .word_dat  (word_dat),
    .word_vld  (word_vld)
  );

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_rx_data_valid) state_nxt = i_rx_data_last ? ST_CHECK : ST_HEADER;
      ST_HEADER:  if (i_rx_data_valid) begin
                    if (i_rx_data_last)       state_nxt = ST_CHECK;
                    else if (hdr_idx == 4'd15) state_nxt = ST_PAYLOAD;
                  end
      ST_PAYLOAD: if (i_rx_data_valid && i_rx_data_last) state_nxt = ST_CHECK;
      ST_CHECK:   state_nxt = err_q ? (in_frame_nxt ? ST_DROP : ST_IDLE) : ST_ISSUE;
      ST_ISSUE:   if (!i_assemble_pkg_is_running) state_nxt = in_frame_nxt ? ST_DROP : ST_IDLE;
      ST_DROP:    if (i_rx_data_valid && i_rx_data_last) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Only a complete, length-consistent 4-byte-payload frame with a known ID escapes NACK
  always_comb begin
    kind_nxt = KIND_NACK;
    if (!runt_q && !oversize && (len_q == 32'(pay_cnt)) && (len_q == 32'd4)) begin
      if (msg_id_q == MSG_ID_REQ)             kind_nxt = KIND_ACK;
      else if (msg_id_q == MSG_ID_STATUS_REQ) kind_nxt = KIND_STATUS;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      kind_q                <= KIND_NACK;
      hdr_idx               <= '0;
      pay_cnt               <= '0;
      len_q                 <= '0;
      pkg_cnt_q             <= '0;
      msg_id_q              <= '0;
      opt_q                 <= '0;
      runt_q                <= 1'b0;
      err_q                 <= 1'b0;
      in_frame              <= 1'b0;
      o_status_request_data <= '0;
      o_rx_pkg_cnt          <= '0;
      o_rx_good_cnt         <= '0;
      o_rx_err_cnt          <= '0;
    end else begin
      in_frame <= in_frame_nxt;
      case (state)
        ST_IDLE: if (i_rx_data_valid) begin
          hdr_idx   <= 4'd1;
          pay_cnt   <= '0;
          len_q     <= '0;
          pkg_cnt_q <= '0;
          msg_id_q  <= '0;
          opt_q     <= '0;
          runt_q    <= i_rx_data_last;
          err_q     <= i_rx_data_last && i_rx_frame_err;
        end
        ST_HEADER: if (i_rx_data_valid) begin
          hdr_idx <= hdr_idx + 4'd1;
          if (word_vld) begin
            case (hdr_idx[3:2])
              2'd0:    len_q     <= word_dat;
              2'd1:    pkg_cnt_q <= word_dat;
              2'd3:    msg_id_q  <= word_dat;
              default: ;
            endcase
          end
          if (i_rx_data_last) begin
            runt_q <= (hdr_idx != 4'd15);
            err_q  <= i_rx_frame_err;
          end
        end
        ST_PAYLOAD: if (i_rx_data_valid) begin
          if (!oversize) pay_cnt <= pay_cnt + PAY_W'(1);
          if (pay_cnt == PAY_W'(3)) opt_q <= word_dat[2:0];
          if (i_rx_data_last) err_q <= i_rx_frame_err;
        end
        ST_CHECK: begin
          kind_q <= kind_nxt;
          if (err_q) begin
            if (o_rx_err_cnt != '1) o_rx_err_cnt <= o_rx_err_cnt + CNT_W'(1);
          end else if (kind_nxt == KIND_STATUS) begin
            o_status_request_data <= opt_q;
          end
        end
        ST_ISSUE: if (!i_assemble_pkg_is_running) begin
          o_rx_pkg_cnt <= pkg_cnt_q;
          if (kind_q == KIND_NACK) begin
            if (o_rx_err_cnt != '1) o_rx_err_cnt <= o_rx_err_cnt + CNT_W'(1);
          end else begin
            if (o_rx_good_cnt != '1) o_rx_good_cnt <= o_rx_good_cnt + CNT_W'(1);
          end
        end
        ST_DROP: if (i_rx_data_valid && i_rx_data_last) begin
          if (o_rx_err_cnt != '1) o_rx_err_cnt <= o_rx_err_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
